twofish_dec_subkey_seq: RTL
===========================

TWOFISH_DEC_SUBKEY_SEQ -- requirements
Module: twofish_dec_subkey_seq

Interface
REQ-001 Parameter HF_LATENCY, default 2: clock cycles from hf_index driven to matching hf_k0/hf_k1 valid.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 key_load  input  1  pulse; starts a subkey table build; key input of the H function is held stable by the source until ready rises.
REQ-006 hf_index  output  6  pair index i (0..19) driven to the external H function.
REQ-007 hf_k0  input  32  even subkey K[2i] from the H function.
REQ-008 hf_k1  input  32  odd subkey K[2i+1] from the H function.
REQ-009 busy  output  1  high while building.
REQ-010 ready  output  1  high while a complete 40-word table is held and no stream is active.
REQ-011 dec_start  input  1  request to stream the table in decryption order; honoured only while ready=1.
REQ-012 sk_data  output  32  streamed subkey word.
REQ-013 sk_valid  output  1  sk_data valid.
REQ-014 sk_ready  input  1  consumer accepts sk_data when sk_valid and sk_ready are both high.
REQ-015 sk_last  output  1  high with the 40th streamed word.

Function
REQ-016 States: IDLE, BUILD, READY, STREAM. Reset enters IDLE.
REQ-017 IDLE/READY/STREAM + key_load -> BUILD; table marked invalid; any stream in progress aborted, sk_valid dropped the next cycle.
REQ-018 BUILD: hf_index steps 0,1,...,19, one value per cycle starting the cycle after key_load; held at 19 after issue ends.
REQ-019 Capture: a delay line of HF_LATENCY stages tracks issued indices; when index j emerges, hf_k0 -> table[2j], hf_k1 -> table[2j+1].
REQ-020 BUILD -> READY the cycle after pair 19 is captured; total build = 20+HF_LATENCY+1 cycles from key_load; busy=1 exactly during BUILD.
REQ-021 key_load during BUILD restarts from index 0; in-flight captures are discarded.
REQ-022 READY + dec_start -> STREAM; ready falls; sk_valid rises the cycle after dec_start is sampled.
REQ-023 Stream order, position p=0..39: p=0..3 -> table[4+p]; p=4..35, q=p-4 -> table[38-2*(q/2)+(q mod 2)]; p=36..39 -> table[p-36]. Sequence: K4..K7, K38,K39, K36,K37, ..., K8,K9, K0..K3.
REQ-024 sk_data and sk_valid hold steady while sk_valid=1 and sk_ready=0.
REQ-025 Throughput: one word per cycle while sk_ready is held high; no bubbles.
REQ-026 sk_last=1 only with p=39; after its acceptance, STREAM -> READY next cycle; sk_valid=0; table retained; repeat dec_start allowed.
REQ-027 dec_start outside READY: ignored. key_load and dec_start in the same cycle: key_load wins.
REQ-028 Table not readable while ready=0 and not in STREAM; sk_valid stays 0.

Reset
REQ-029 On rst: state IDLE; hf_index=0; busy=0; ready=0; sk_valid=0; sk_last=0; sk_data=0; delay line cleared; table marked invalid (contents need not be cleared).
REQ-030 rst overrides key_load and dec_start in the same cycle; rst mid-BUILD or mid-STREAM aborts; a new key_load is required.

Verification
REQ-031 H-function model (latency 2) returns hf_k0=32'hA000_0000+2i, hf_k1=32'hA000_0000+2i+1; key_load pulse -> busy high 23 cycles, ready=1 on cycle 24, table[n]=32'hA000_0000+n.
REQ-032 Stream with sk_ready=1 -> 40 consecutive words: A0000004..A0000007, A0000026, A0000027, A0000024, ..., A0000008, A0000009, A0000000..A0000003; sk_last only on A0000003.
REQ-033 Stream with sk_ready toggling 1,0,0,1 -> no word lost or duplicated; sk_data stable during stalls; same 40-word sequence.
REQ-034 key_load at build cycle 10, model offset changed to 32'hB000_0000 -> table holds only B-values; no A-value ever streamed.
REQ-035 key_load at stream word 15 -> sk_valid low the next cycle; rebuild completes; next stream restarts at p=0.
REQ-036 rst asserted mid-STREAM -> all outputs at reset values the next cycle; dec_start ignored until rebuild completes.

Source files
------------

// File: rtl/twofish_dec_subkey_seq.sv
// Twofish decryption subkey sequencer: builds the 40-word subkey table from an
// external pipelined H function, then streams it out in decryption order.
module twofish_dec_subkey_seq #(
  parameter int HF_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  output logic [5:0]  hf_index,
  input  logic [31:0] hf_k0,
  input  logic [31:0] hf_k1,
  output logic        busy,
  output logic        ready,
  input  logic        dec_start,
  output logic [31:0] sk_data,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic        sk_last
);

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_READY, S_STREAM} state_t;

  state_t      state_q, state_d;
  logic [4:0]  hf_index_q, hf_index_d;
  logic        issue_q, issue_d;
  logic        cap_done_q, cap_done_d;
  logic [HF_LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [4:0]  dl_idx_q [HF_LATENCY];
  logic [4:0]  dl_idx_d [HF_LATENCY];
  logic [5:0]  pos_q, pos_d;
  logic [31:0] sk_data_q, sk_data_d;
  logic        sk_valid_q, sk_valid_d;
  logic        sk_last_q, sk_last_d;
  logic        cap_en;
  logic [4:0]  cap_pair;
  logic [31:0] sk_table [40];

  // Stream position -> table address: K4..K7, pairs 19 down to 4, then K0..K3.
  function automatic logic [5:0] stream_addr(input logic [5:0] p);
    logic [5:0] q;
    q = p - 6'd4;
    if (p < 6'd4)       return p + 6'd4;
    else if (p < 6'd36) return 6'd38 - {q[5:1], 1'b0} + {5'd0, q[0]};
    else                return p - 6'd36;
  endfunction

  always_comb begin
    state_d    = state_q;
    hf_index_d = hf_index_q;
    issue_d    = issue_q;
    cap_done_d = cap_done_q;
    pos_d      = pos_q;
    sk_data_d  = sk_data_q;
    sk_valid_d = sk_valid_q;
    sk_last_d  = sk_last_q;

    dl_vld_d[0] = (state_q == S_BUILD) && issue_q;
    dl_idx_d[0] = hf_index_q;
    for (int k = 1; k < HF_LATENCY; k++) begin
      dl_vld_d[k] = dl_vld_q[k-1];
      dl_idx_d[k] = dl_idx_q[k-1];
    end

    cap_en   = dl_vld_q[HF_LATENCY-1] && (state_q == S_BUILD) && !key_load;
    cap_pair = dl_idx_q[HF_LATENCY-1];
    if (cap_en && cap_pair == 5'd19) cap_done_d = 1'b1;

    case (state_q)
      S_BUILD: begin
        if (issue_q) begin
          if (hf_index_q == 5'd19) issue_d = 1'b0;
          else                     hf_index_d = hf_index_q + 5'd1;
        end
        if (cap_done_q) state_d = S_READY;
      end
      S_READY: begin
        if (dec_start) begin
          state_d    = S_STREAM;
          sk_data_d  = sk_table[stream_addr(6'd0)];
          sk_valid_d = 1'b1;
          sk_last_d  = 1'b0;
          pos_d      = 6'd1;
        end
      end
      S_STREAM: begin
        if (sk_valid_q && sk_ready) begin
          if (sk_last_q) begin
            sk_valid_d = 1'b0;
            sk_last_d  = 1'b0;
            state_d    = S_READY;
          end else begin
            sk_data_d = sk_table[stream_addr(pos_q)];
            sk_last_d = (pos_q == 6'd39);
            pos_d     = pos_q + 6'd1;
          end
        end
      end
      default: ;
    endcase

    // A new key always wins: restart the build and drop any stream or capture.
    if (key_load) begin
      state_d    = S_BUILD;
      hf_index_d = 5'd0;
      issue_d    = 1'b1;
      cap_done_d = 1'b0;
      dl_vld_d   = '0;
      sk_valid_d = 1'b0;
      sk_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hf_index_q <= 5'd0;
      issue_q    <= 1'b0;
      cap_done_q <= 1'b0;
      dl_vld_q   <= '0;
      for (int k = 0; k < HF_LATENCY; k++) dl_idx_q[k] <= 5'd0;
      pos_q      <= 6'd0;
      sk_data_q  <= 32'd0;
      sk_valid_q <= 1'b0;
      sk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hf_index_q <= hf_index_d;
      issue_q    <= issue_d;
      cap_done_q <= cap_done_d;
      dl_vld_q   <= dl_vld_d;
      for (int k = 0; k < HF_LATENCY; k++) dl_idx_q[k] <= dl_idx_d[k];
      pos_q      <= pos_d;
      sk_data_q  <= sk_data_d;
      sk_valid_q <= sk_valid_d;
      sk_last_q  <= sk_last_d;
    end
  end

  // Table contents need no reset; validity is tracked by the state machine.
  always_ff @(posedge clk) begin
    if (!rst && cap_en) begin
      sk_table[{1'b0, cap_pair} << 1]          <= hf_k0;
      sk_table[({1'b0, cap_pair} << 1) | 6'd1] <= hf_k1;
    end
  end

  assign hf_index = {1'b0, hf_index_q};
  assign busy     = (state_q == S_BUILD);
  assign ready    = (state_q == S_READY);
  assign sk_data  = sk_data_q;
  assign sk_valid = sk_valid_q;
  assign sk_last  = sk_last_q;

endmodule
